// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU. One 1-bit slice is run LSB-first, one bit per
// clock, with a registered carry between bits. Valid/ready handshake on both
// sides; F/CarryOut/Zero are registered and hold until the next result.
// Optional feature: define ALU_SERIAL_OVERFLOW_EN to add a registered
// two's-complement Overflow output for the arithmetic modes.
module alu_serial #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic             S1,
    input  logic             S0,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] F,
    output logic             CarryOut,
    output logic             Zero
`ifdef ALU_SERIAL_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_INC  = 2'b00,  // A + CarryIn
        MODE_ADD  = 2'b01,  // A + B + CarryIn
        MODE_ANDN = 2'b10,  // A & ~B
        MODE_NOT  = 2'b11   // ~A
    } mode_t;

    state_t           state;
    state_t           state_next;
    mode_t            mode;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] f_shift;
    logic [WIDTH-1:0] f_final;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             bit_f;
    logic             bit_c;
    logic             accept;
    logic             last_bit;

    assign accept   = InValid && InReady;
    assign last_bit = (state == RUN) && (cnt == LAST_BIT);
    // The final bit enters at the MSB in the same edge F is loaded.
    assign f_final  = {bit_f, f_shift[WIDTH-1:1]};

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from the values seen just before the edge.
    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the MSB,
    // DONE -> IDLE once the consumer takes the result.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (OutReady) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        InReady  = (state == IDLE);
        OutValid = (state == DONE);
    end

    // One-bit ALU slice operating on the current LSB of the shifted operands.
    always_comb begin
        bit_f = 1'b0;
        bit_c = 1'b0;
        case (mode)
            MODE_INC: begin
                bit_f = a_sh[0] ^ carry;
                bit_c = a_sh[0] & carry;
            end
            MODE_ADD: begin
                bit_f = a_sh[0] ^ b_sh[0] ^ carry;
                bit_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
            end
            MODE_ANDN: bit_f = a_sh[0] & ~b_sh[0];
            MODE_NOT:  bit_f = ~a_sh[0];
            default: ;
        endcase
    end

    // Operand capture and per-bit shifting.
    // NOTE: these datapath registers are deliberately not reset; they are
    // always fully loaded at accept and rewritten before F is updated.
    always_ff @(posedge Clock) begin
        if (accept) begin
            a_sh <= A;
            b_sh <= B;
            mode <= mode_t'({S1, S0});
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            f_shift <= f_final;
        end
    end

    // Bit counter, carry chain and registered result/status flags.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt      <= '0;
            carry    <= 1'b0;
            F        <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b0;
`ifdef ALU_SERIAL_OVERFLOW_EN
            Overflow <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            carry <= CarryIn;
        end else if (state == RUN) begin
            cnt   <= cnt + CNT_W'(1);
            carry <= bit_c;
            if (last_bit) begin
                F        <= f_final;
                CarryOut <= bit_c;
                Zero     <= (f_final == '0);
`ifdef ALU_SERIAL_OVERFLOW_EN
                // Carry into the MSB versus carry out of it; logic modes never overflow.
                Overflow <= ~mode[1] & (carry ^ bit_c);
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: randomized self-checking bench for alu_serial. Results are
// compared against a word-level arithmetic model. An 8-bit and a 16-bit
// instance share clock and reset.
module tb_alu_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit instance signals
    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic       s1_8, s0_8, cin8, cout8, zero8;
    logic [7:0] a8, b8, f8;
    // 16-bit instance signals
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic        s1_16, s0_16, cin16, cout16, zero16;
    logic [15:0] a16, b16, f16;
`ifdef ALU_SERIAL_OVERFLOW_EN
    logic ov8, ov16;
`endif

    alu_serial #(.WIDTH(8)) dut8 (
        .Clock(clk), .Reset(rst), .InValid(in_valid8), .InReady(in_ready8),
        .S1(s1_8), .S0(s0_8), .A(a8), .B(b8), .CarryIn(cin8),
        .OutValid(out_valid8), .OutReady(out_ready8), .F(f8),
        .CarryOut(cout8), .Zero(zero8)
`ifdef ALU_SERIAL_OVERFLOW_EN
        , .Overflow(ov8)
`endif
    );

    alu_serial #(.WIDTH(16)) dut16 (
        .Clock(clk), .Reset(rst), .InValid(in_valid16), .InReady(in_ready16),
        .S1(s1_16), .S0(s0_16), .A(a16), .B(b16), .CarryIn(cin16),
        .OutValid(out_valid16), .OutReady(out_ready16), .F(f16),
        .CarryOut(cout16), .Zero(zero16)
`ifdef ALU_SERIAL_OVERFLOW_EN
        , .Overflow(ov16)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level reference: plain modular arithmetic and signed-overflow rule.
    function automatic void model(input int w, input logic [1:0] s,
                                  input logic [31:0] a, input logic [31:0] b, input logic cin,
                                  output logic [31:0] f, output logic co, output logic ov);
        logic [63:0] mask;
        logic [63:0] sum;
        logic        sa, sb, sf;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1];
        sb   = b[w-1];
        co   = 1'b0;
        ov   = 1'b0;
        case (s)
            2'b00: begin
                sum = 64'(a) + 64'(cin);
                f   = 32'(sum & mask);
                co  = sum[w];
                sf  = f[w-1];
                ov  = !sa && sf;
            end
            2'b01: begin
                sum = 64'(a) + 64'(b) + 64'(cin);
                f   = 32'(sum & mask);
                co  = sum[w];
                sf  = f[w-1];
                ov  = (sa == sb) && (sf != sa);
            end
            2'b10:   f = 32'(64'(a & ~b) & mask);
            default: f = 32'(64'(~a) & mask);
        endcase
    endfunction

    // Present a bundle to the 8-bit instance and return just after the accept
    // edge, with the inputs scrambled so late changes would be visible.
    task automatic start8(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                          input logic cin);
        @(negedge clk);
        check("idle_ready8", 32'(in_ready8), 32'd1);
        {s1_8, s0_8} = s; a8 = a; b8 = b; cin8 = cin;
        in_valid8 = 1'b1;
        out_ready8 = 1'b0;
        @(negedge clk);
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        {s1_8, s0_8} = 2'($urandom); cin8 = 1'($urandom);
    endtask

    // Wait for and check the result of an accepted 8-bit bundle. Optionally
    // stall the consumer and present a second bundle during the stall.
    task automatic finish8(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input int stall, input bit push_next,
                           input logic [1:0] ns, input logic [7:0] na, input logic [7:0] nb,
                           input logic ncin);
        logic [31:0] ef;
        logic        eco, eov;
        int          lat;
        model(8, s, 32'(a), 32'(b), cin, ef, eco, eov);
        check("busy8", 32'(in_ready8), 32'd0);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", 32'(lat), 32'd8);
        check("f8", 32'(f8), ef);
        check("cout8", 32'(cout8), 32'(eco));
        check("zero8", 32'(zero8), 32'(ef == 0));
`ifdef ALU_SERIAL_OVERFLOW_EN
        check("ovf8", 32'(ov8), 32'(eov));
`endif
        if (push_next) begin
            {s1_8, s0_8} = ns; a8 = na; b8 = nb; cin8 = ncin;
            in_valid8 = 1'b1;
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("hold_valid8", 32'(out_valid8), 32'd1);
            check("hold_f8", 32'(f8), ef);
            check("hold_busy8", 32'(in_ready8), 32'd0);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        out_ready8 = 1'b0;
        check("released8", 32'(out_valid8), 32'd0);
        check("back_idle8", 32'(in_ready8), 32'd1);
        check("f_kept8", 32'(f8), ef);
        if (push_next) begin
            @(negedge clk);
            check("next_accepted8", 32'(in_ready8), 32'd0);
            in_valid8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
    endtask

    // One complete operation on the 16-bit instance.
    task automatic op16(input logic [1:0] s, input logic [15:0] a, input logic [15:0] b,
                        input logic cin);
        logic [31:0] ef;
        logic        eco, eov;
        int          lat;
        model(16, s, 32'(a), 32'(b), cin, ef, eco, eov);
        @(negedge clk);
        check("idle_ready16", 32'(in_ready16), 32'd1);
        {s1_16, s0_16} = s; a16 = a; b16 = b; cin16 = cin;
        in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0;
        while (!out_valid16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("latency16", 32'(lat), 32'd16);
        check("f16", 32'(f16), ef);
        check("cout16", 32'(cout16), 32'(eco));
        check("zero16", 32'(zero16), 32'(ef == 0));
`ifdef ALU_SERIAL_OVERFLOW_EN
        check("ovf16", 32'(ov16), 32'(eov));
`endif
        out_ready16 = 1'b1;
        @(negedge clk);
        out_ready16 = 1'b0;
        check("released16", 32'(out_valid16), 32'd0);
    endtask

    initial begin
        logic [1:0] s;
        logic [7:0] a, b;
        logic       c;
        int         seen;

        rst = 1'b1;
        in_valid8 = 0; out_ready8 = 0; s1_8 = 0; s0_8 = 0; a8 = 0; b8 = 0; cin8 = 0;
        in_valid16 = 0; out_ready16 = 0; s1_16 = 0; s0_16 = 0; a16 = 0; b16 = 0; cin16 = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready8), 32'd1);
        check("rst_valid", 32'(out_valid8), 32'd0);
        check("rst_f", 32'(f8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_zero", 32'(zero8), 32'd0);
        rst = 1'b0;

        // Directed cases
        start8(2'b01, 8'hFF, 8'h01, 1'b0); finish8(2'b01, 8'hFF, 8'h01, 1'b0, 0, 0, 0, 0, 0, 0);
        start8(2'b00, 8'h7F, 8'h00, 1'b1); finish8(2'b00, 8'h7F, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0);
        start8(2'b10, 8'hF0, 8'h3C, 1'b0); finish8(2'b10, 8'hF0, 8'h3C, 1'b0, 0, 0, 0, 0, 0, 0);
        start8(2'b11, 8'h00, 8'h00, 1'b1); finish8(2'b11, 8'h00, 8'h00, 1'b1, 0, 0, 0, 0, 0, 0);

        // Backpressure: five stalled cycles with a second bundle offered.
        start8(2'b01, 8'h12, 8'h34, 1'b1);
        finish8(2'b01, 8'h12, 8'h34, 1'b1, 5, 1, 2'b00, 8'h80, 8'h55, 1'b1);
        finish8(2'b00, 8'h80, 8'h55, 1'b1, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of RUN discards the operation.
        start8(2'b01, 8'hFF, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(in_ready8), 32'd1);
        check("midrst_valid", 32'(out_valid8), 32'd0);
        check("midrst_f", 32'(f8), 32'd0);
        check("midrst_cout", 32'(cout8), 32'd0);
        out_ready8 = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid8) seen++;
        end
        out_ready8 = 1'b0;
        check("midrst_no_valid", 32'(seen), 32'd0);

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            s = 2'($urandom); a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            start8(s, a, b, c);
            finish8(s, a, b, c, int'($urandom_range(0, 3)), 0, 0, 0, 0, 0);
        end

        // Wider instance
        op16(2'b01, 16'h8000, 16'h8000, 1'b1);
        for (int i = 0; i < 8; i++)
            op16(2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
